// File: rtl/mdu.sv
// mdu -- iterative multiply/divide unit with HI/LO registers.
// Multiplies by shift-add and divides by restoring division, one bit per cycle.
// Each operation spends 32 iterate cycles plus one FIX cycle, so done rises
// 33 cycles after the start edge. MTHI/MTLO write HI/LO directly when idle.
// Optional feature: define MDU_SIGNED_EN to build signed MULT/DIV. Without it,
// op 001 runs as MULTU and op 011 runs as DIVU.
module mdu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t      r_state;
    state_t      w_state_next;

    // Iteration datapath: r_acc holds {partial product} for MUL and
    // {partial remainder, dividend/quotient bits} for DIV.
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opnd;     // multiplicand or divisor magnitude
    logic [31:0] r_a_orig;   // original a, returned as HI on divide by zero
    logic        r_is_div;
    logic        r_div0;

    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_start_mul;
    logic        w_start_div;
    logic        w_load_hi;
    logic        w_load_lo;
    logic        w_finish;
    logic        w_busy;

    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_sum;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [63:0] w_prod;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

`ifdef MDU_SIGNED_EN
    logic        w_signed;
    logic        r_neg_q;    // negate product/quotient: sign(a) XOR sign(b)
    logic        r_neg_r;    // negate remainder: it follows the sign of a

    assign w_signed = (op == OP_MULT) || (op == OP_DIV);
    assign w_a_mag  = (w_signed && a[31]) ? (32'd0 - a) : a;
    assign w_b_mag  = (w_signed && b[31]) ? (32'd0 - b) : b;
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
`endif

    // One shift-add multiply step: add multiplicand when the current
    // multiplier bit is set, then shift the whole accumulator right.
    assign w_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opnd : 32'd0)};

    // One restoring divide step. The shifted remainder needs 33 bits; when the
    // subtraction succeeds the difference is below the divisor, so 32 bits hold it.
    assign w_shift = {r_acc[63:32], r_acc[31]};
    assign w_ge    = (w_shift >= {1'b0, r_opnd});
    assign w_sub   = w_shift[31:0] - r_opnd;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_state_next = r_state;
        w_start_mul  = 1'b0;
        w_start_div  = 1'b0;
        w_load_hi    = 1'b0;
        w_load_lo    = 1'b0;
        w_finish     = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (start) begin
                    case (op)
                        OP_MULTU, OP_MULT: begin
                            w_start_mul  = 1'b1;
                            w_state_next = MUL;
                        end
                        OP_DIVU, OP_DIV: begin
                            w_start_div  = 1'b1;
                            w_state_next = DIV;
                        end
                        OP_MTHI: w_load_hi = 1'b1;
                        OP_MTLO: w_load_lo = 1'b1;
                        default: ;  // reserved codes do nothing
                    endcase
                end
            end
            MUL: begin
                if (r_cnt == 5'd31) w_state_next = FIX;
            end
            DIV: begin
                if (r_cnt == 5'd31) w_state_next = FIX;
            end
            FIX: begin
                w_finish     = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Iteration datapath: load operands on start, then one bit per cycle.
    always_ff @(posedge clk) begin
        // NOTE: these datapath registers carry no reset; they are always
        // loaded on start before being read, and only state/hi/lo/done must
        // come up known.
        if (w_start_mul || w_start_div) begin
            r_cnt    <= 5'd0;
            r_is_div <= w_start_div;
            r_div0   <= (b == 32'd0);
            r_a_orig <= a;
            if (w_start_div) begin
                r_acc  <= {32'd0, w_a_mag};
                r_opnd <= w_b_mag;
            end else begin
                r_acc  <= {32'd0, w_b_mag};
                r_opnd <= w_a_mag;
            end
`ifdef MDU_SIGNED_EN
            r_neg_q <= w_signed && (a[31] ^ b[31]);
            r_neg_r <= w_signed && a[31];
`endif
        end else if (r_state == MUL) begin
            r_cnt <= r_cnt + 5'd1;
            r_acc <= {w_sum, r_acc[31:1]};
        end else if (r_state == DIV) begin
            r_cnt <= r_cnt + 5'd1;
            if (w_ge) begin
                r_acc <= {w_sub, r_acc[30:0], 1'b1};
            end else begin
                r_acc <= {w_shift[31:0], r_acc[30:0], 1'b0};
            end
        end
    end

    // Result formation in FIX: sign fixup and the divide-by-zero override.
    // 0x80000000 / -1 needs no special case: |a|/|b| = 0x80000000 and the
    // signs match, so the raw quotient is already the required result.
    always_comb begin
        w_prod = r_acc;
        w_quot = r_acc[31:0];
        w_rem  = r_acc[63:32];
`ifdef MDU_SIGNED_EN
        if (r_neg_q) begin
            w_prod = 64'd0 - r_acc;
            w_quot = 32'd0 - r_acc[31:0];
        end
        if (r_neg_r) begin
            w_rem = 32'd0 - r_acc[63:32];
        end
`endif
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_div0) begin
                w_res_hi = r_a_orig;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    // HI/LO and done: written in FIX, or directly by MTHI/MTLO when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
            if (w_finish) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else begin
                if (w_load_hi) r_hi <= a;
                if (w_load_lo) r_lo <= a;
            end
        end
    end

    assign busy = w_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu -- table-driven directed bench for mdu, plus hand sequences for
// start-while-busy, MTHI/MTLO, reserved ops and reset abort.
// Expected values follow the MDU_SIGNED_EN setting of the build.
module tb_mdu;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_pass;

    // Expected HI/LO as tracked by the bench.
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    vec_t vecs[11];

    mdu dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply/divide and check latency, busy length, HI/LO hold,
    // result and done pulse width. inject_at > 0 drives an MTHI request
    // that many cycles after the start edge; it must be ignored.
    task automatic run_op(input string name, input logic [2:0] op_i,
                          input logic [31:0] a_i, input logic [31:0] b_i,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int inject_at);
        int lat;
        int busy_cycles;
        int held_bad;
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        b     = b_i;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        lat = 0;
        busy_cycles = 0;
        held_bad = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            if (hi !== m_hi || lo !== m_lo) held_bad++;
            if (inject_at > 0 && lat == inject_at) begin
                start = 1'b1;
                op    = OP_MTHI;
                a     = 32'h1234_5678;
            end else begin
                start = 1'b0;
            end
            tick();
            lat++;
        end
        start = 1'b0;
        check({name, " latency"}, 64'(lat), 64'd33);
        check({name, " busy_cycles"}, 64'(busy_cycles), 64'd33);
        check({name, " hilo_held"}, 64'(held_bad), 64'd0);
        check({name, " busy_at_done"}, 64'(busy), 64'd0);
        check({name, " hi"}, 64'(hi), 64'(exp_hi));
        check({name, " lo"}, 64'(lo), 64'(exp_lo));
        m_hi = exp_hi;
        m_lo = exp_lo;
        tick();
        check({name, " done_width"}, 64'(done), 64'd0);
    endtask

    initial begin
        int done_seen;
        n_checks = 0;
        n_pass   = 0;
        m_hi     = 32'd0;
        m_lo     = 32'd0;

        vecs[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[1] = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[2] = '{OP_DIVU,  32'd1000,      32'd7,         32'd6,         32'd142};
        vecs[3] = '{OP_DIVU,  32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF};
        vecs[4] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};
        vecs[5] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};
`ifdef MDU_SIGNED_EN
        vecs[6]  = '{OP_MULT, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[7]  = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[9]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[10] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
`else
        vecs[6]  = '{OP_MULT, 32'hFFFF_FFFD, 32'd7,         32'h0000_0006, 32'hFFFF_FFEB};
        vecs[7]  = '{OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[8]  = '{OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC};
        vecs[9]  = '{OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        vecs[10] = '{OP_DIV,  32'd7,         32'hFFFF_FFFE, 32'h0000_0007, 32'h0000_0000};
`endif

        // Reset with a pending MTHI request: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'hFFFF_FFFF;
        b     = 32'd0;
        tick();
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);

        for (int i = 0; i < 11; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 0);
        end

        // MTHI request arriving mid-divide is ignored.
        run_op("divu_inject", OP_DIVU, 32'd1000, 32'd7, 32'd6, 32'd142, 5);

        // MTHI then MTLO from idle: immediate write, no busy, no done.
        start = 1'b1;
        op    = OP_MTHI;
        a     = 32'h1234_5678;
        tick();
        start = 1'b0;
        check("mthi hi", 64'(hi), 64'h1234_5678);
        check("mthi lo", 64'(lo), 64'(m_lo));
        check("mthi busy", 64'(busy), 64'd0);
        check("mthi done", 64'(done), 64'd0);
        m_hi  = 32'h1234_5678;
        start = 1'b1;
        op    = OP_MTLO;
        a     = 32'hCAFE_F00D;
        tick();
        start = 1'b0;
        check("mtlo lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo hi", 64'(hi), 64'(m_hi));
        check("mtlo done", 64'(done), 64'd0);
        m_lo = 32'hCAFE_F00D;

        // Reserved op codes do nothing.
        start = 1'b1;
        op    = 3'b110;
        a     = 32'hDEAD_BEEF;
        b     = 32'd3;
        tick();
        op    = 3'b111;
        tick();
        start = 1'b0;
        check("reserved busy", 64'(busy), 64'd0);
        check("reserved hi", 64'(hi), 64'(m_hi));
        check("reserved lo", 64'(lo), 64'(m_lo));
        check("reserved done", 64'(done), 64'd0);

        // Reset ten cycles into a multiply aborts it without a done pulse.
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'hFFFF_FFFF;
        b     = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("abort busy_before", 64'(busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort no_done", 64'(done_seen), 64'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        run_op("multu_after_abort", OP_MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 SHALL have parameter: none (widths fixed at 32 bits, matching the register file data path).
REQ-002 SHALL have port `clk`  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port `start`  input  1  operation request, sampled on the rising edge.
REQ-005 SHALL have port `op`  input  3  operation code: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 SHALL have port `a`  input  32  first operand (rs, driven from register file rd1).
REQ-007 SHALL have port `b`  input  32  second operand (rt, driven from register file rd2).
REQ-008 SHALL have port `busy`  output  1  high while a multiply or divide is in progress.
REQ-009 SHALL have port `done`  output  1  one-cycle pulse when `hi`/`lo` receive a multiply or divide result.
REQ-010 SHALL have port `hi`  output  32  HI register (product high word / remainder), feeding the register file wd path for MFHI.
REQ-011 SHALL have port `lo`  output  32  LO register (product low word / quotient), feeding the register file wd path for MFLO.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX.
REQ-013 SHALL, in IDLE with start=1 and op=MULT/MULTU/DIV/DIVU, latch a and b, go to MUL or DIV, and assert busy from the next cycle.
REQ-014 SHALL iterate one bit per cycle: 32 cycles in MUL (shift-add) or DIV (restoring), then one cycle in FIX.
REQ-015 SHALL, in FIX, write hi/lo, return to IDLE, drop busy, and pulse done; done is therefore high exactly 33 cycles after the start edge.
REQ-016 SHALL hold hi/lo at their previous values while busy=1.
REQ-017 SHALL, in IDLE with start=1 and op=MTHI or MTLO, write a to hi or lo at that edge, with no busy and no done.
REQ-018 SHALL ignore start while busy=1, and SHALL ignore reserved op codes in any state.
REQ-019 SHALL, for signed ops, operate on magnitudes; the quotient/product is negated when sign(a) XOR sign(b), and the remainder takes the sign of a.
REQ-020 SHALL, on divide by zero, produce lo=0xFFFFFFFF and hi=a (original operand), in both signed and unsigned modes.
REQ-021 SHALL, for DIV 0x80000000 / 0xFFFFFFFF, produce lo=0x80000000 and hi=0x00000000.

Reset
REQ-022 SHALL, when rst=1 at a rising edge, set state=IDLE, busy=0, done=0, hi=0, lo=0, regardless of start.
REQ-023 SHALL abort an operation in progress on reset; no done pulse is produced for the aborted operation.

Configuration
REQ-024 SHALL compile signed support (MULT, DIV, REQ-019, REQ-021) only when the macro MDU_SIGNED_EN is defined.
REQ-025 SHALL, without MDU_SIGNED_EN, execute op 001 as MULTU and op 011 as DIVU, and omit the sign-fixup logic; FIX still takes one cycle, so latency is unchanged.

Verification
REQ-026 Scenario: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done 33 cycles after the start edge, hi=0xFFFFFFFE, lo=0x00000001, busy high for exactly 33 cycles.
REQ-027 Scenario: MULT a=0xFFFFFFFD, b=7 -> with MDU_SIGNED_EN, hi=0xFFFFFFFF, lo=0xFFFFFFEB; without the macro, hi=0x00000006, lo=0xFFFFFFEB.
REQ-028 Scenario: DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-029 Scenario: DIVU a=100, b=0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-030 Scenario: start DIVU; at cycle 5 drive start with MTHI a=0x12345678 -> ignored, hi unchanged until FIX; after done, MTHI a=0x12345678 -> hi=0x12345678 next cycle, done stays 0.
REQ-031 Scenario: start MULTU, assert rst at cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; a new MULTU 3x5 then gives lo=15, hi=0.
